// File: rtl/i2c_addr_pkg.sv
// Shared types and constants for the I2C address-phase sequencer.
// Optional retry-on-NACK is enabled with I2C_ADDR_RETRY_EN.
package i2c_addr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    ACK,
    RSTART,
    DONE
  } state_e;

  typedef logic [1:0] byte_idx_t;

  localparam logic [4:0] TEN_BIT_PREFIX = 5'b11110;

  localparam int TICKS_7BIT     = 10;
  localparam int TICKS_10BIT_WR = 19;
  localparam int TICKS_10BIT_RD = 29;

  // B0/B1/B2 of the address phase for the captured request
  function automatic logic [7:0] addrByte(
    input byte_idx_t   idx,
    input logic        tenBit,
    input logic [9:0]  addr,
    input logic        rw
  );
    logic [7:0] b;
    if (!tenBit)
      b = {addr[6:0], rw};
    else if (idx == 2'd1)
      b = addr[7:0];
    else if (idx == 2'd2)
      b = {TEN_BIT_PREFIX, addr[9:8], 1'b1};
    else
      b = {TEN_BIT_PREFIX, addr[9:8], 1'b0};
    return b;
  endfunction

endpackage

// File: rtl/i2c_addr_sequencer_shifter.sv
// MSB-first byte shifter for the address phase.
// Flags the 8th bit of the loaded byte.
module i2c_byte_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] loadByte,
  input  logic       shift,
  output logic       msb,
  output logic       lastBit
);

  logic [7:0] shreg;
  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= loadByte;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= {shreg[6:0], 1'b0};
      cnt   <= cnt + 3'd1;
    end
  end

  assign msb     = shreg[7];
  assign lastBit = (cnt == 3'd7);

endmodule

// File: rtl/i2c_addr_sequencer.sv
// I2C address-phase sequencer: 7/10-bit, MSB-first, 10-bit read RSTART.
// Define I2C_ADDR_RETRY_EN to retry the address on NACK.
module i2c_addr_sequencer
  import i2c_addr_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int RETRY_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               ten_bit,
  input  logic [9:0]         addr,
  input  logic               rw,
  input  logic               bit_tick,
  input  logic               slave_ack,
  output logic               busy,
  output logic               start_req,
  output logic               sda_bit,
  output logic               bit_valid,
  output logic               ack_slot,
  output logic               done,
  output logic               addr_ack,
  output logic               nack_err,
  output logic               stop_req,
  output logic [RETRY_W-1:0] retry_cnt
);

  if (MAX_RETRY >= (1 << RETRY_W)) begin : gRetryRange
    $error("MAX_RETRY does not fit in RETRY_W bits");
  end

  state_e     state, stateNxt;
  byte_idx_t  idx, idxNxt, loadIdx;
  logic       tenBitQ, rwQ;
  logic [9:0] addrQ;
  logic       addrAckQ, nackErrQ;
  logic       setAck, setNack;
  logic       load, shift, msb, lastBit;
  logic       accept, retryOk;

  assign accept = (state == IDLE) && start;

  i2c_byte_shifter uShifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .loadByte (addrByte(loadIdx, tenBitQ, addrQ, rwQ)),
    .shift    (shift),
    .msb      (msb),
    .lastBit  (lastBit)
  );

`ifdef I2C_ADDR_RETRY_EN
  logic [RETRY_W-1:0] retryQ;

  assign retryOk = int'(retryQ) < MAX_RETRY;

  always_ff @(posedge clk) begin
    if (!rst_n)
      retryQ <= '0;
    else if (accept)
      retryQ <= '0;
    else if (state == ACK && bit_tick
             && !slave_ack && retryOk)
      retryQ <= retryQ + RETRY_W'(1);
  end

  assign retry_cnt = retryQ;
`else
  assign retryOk   = 1'b0;
  assign retry_cnt = '0;
`endif

  always_comb begin
    stateNxt = state;
    idxNxt   = idx;
    loadIdx  = idx;
    load     = 1'b0;
    shift    = 1'b0;
    setAck   = 1'b0;
    setNack  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          stateNxt = START;
          idxNxt   = 2'd0;
        end
      end
      START: begin
        if (bit_tick) begin
          load     = 1'b1;
          loadIdx  = 2'd0;
          idxNxt   = 2'd0;
          stateNxt = SHIFT;
        end
      end
      RSTART: begin
        if (bit_tick) begin
          load     = 1'b1;
          loadIdx  = 2'd2;
          idxNxt   = 2'd2;
          stateNxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_tick) begin
          shift = 1'b1;
          if (lastBit)
            stateNxt = ACK;
        end
      end
      ACK: begin
        if (bit_tick) begin
          unique case (1'b1)
            slave_ack && tenBitQ
              && idx == 2'd0: begin
              load     = 1'b1;
              loadIdx  = 2'd1;
              idxNxt   = 2'd1;
              stateNxt = SHIFT;
            end
            slave_ack && tenBitQ
              && rwQ && idx == 2'd1: begin
              stateNxt = RSTART;
            end
            !slave_ack && retryOk: begin
              // retry restarts from B0
              stateNxt = START;
            end
            default: begin
              stateNxt = DONE;
              setAck   = slave_ack;
              setNack  = !slave_ack;
            end
          endcase
        end
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      tenBitQ  <= 1'b0;
      rwQ      <= 1'b0;
      addrQ    <= '0;
      addrAckQ <= 1'b0;
      nackErrQ <= 1'b0;
    end else begin
      state <= stateNxt;
      idx   <= idxNxt;
      if (accept) begin
        tenBitQ  <= ten_bit;
        rwQ      <= rw;
        addrQ    <= addr;
        addrAckQ <= 1'b0;
        nackErrQ <= 1'b0;
      end
      if (setAck)
        addrAckQ <= 1'b1;
      if (setNack)
        nackErrQ <= 1'b1;
    end
  end

  assign busy      = (state == START) || (state == SHIFT)
                  || (state == ACK) || (state == RSTART);
  assign start_req = (state == START) || (state == RSTART);
  assign bit_valid = (state == SHIFT);
  assign sda_bit   = bit_valid & msb;
  assign ack_slot  = (state == ACK);
  assign done      = (state == DONE);
  assign addr_ack  = addrAckQ;
  assign nack_err  = nackErrQ;
  assign stop_req  = done & nackErrQ;

endmodule

// File: tb/tb_i2c_addr_sequencer.sv
// Self-checking bench for i2c_addr_sequencer (random tick spacing,
// slot-level reference model; retry cases follow I2C_ADDR_RETRY_EN).
module tb_i2c_addr_sequencer;
  import i2c_addr_pkg::*;

  localparam int MAXR = 2;
`ifdef I2C_ADDR_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, ten_bit, rw, bit_tick, slave_ack;
  logic [9:0] addr;
  logic       busy, start_req, sda_bit, bit_valid, ack_slot;
  logic       done, addr_ack, nack_err, stop_req;
  logic [1:0] retry_cnt;

  int nChecks = 0;
  int nFails  = 0;

  // slot events: -1 (re)START, 0/1 data bit, 2 ACK slot, 9 no slot
  int ackPlan[$];
  int expEv[$];
  int obsEv[$];
  int expAck, expNack, expRetry;

  always #5 clk = ~clk;

  i2c_addr_sequencer #(.MAX_RETRY(MAXR), .RETRY_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ten_bit   (ten_bit),
    .addr      (addr),
    .rw        (rw),
    .bit_tick  (bit_tick),
    .slave_ack (slave_ack),
    .busy      (busy),
    .start_req (start_req),
    .sda_bit   (sda_bit),
    .bit_valid (bit_valid),
    .ack_slot  (ack_slot),
    .done      (done),
    .addr_ack  (addr_ack),
    .nack_err  (nack_err),
    .stop_req  (stop_req),
    .retry_cnt (retry_cnt)
  );

  task automatic check(input string tag, input int obs,
                       input int expv);
    nChecks++;
    assert (obs === expv) else begin
      nFails++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, expv);
    end
  endtask

  function automatic int allOut();
    return int'({busy, start_req, sda_bit, bit_valid, ack_slot,
                 done, addr_ack, nack_err, stop_req, retry_cnt});
  endfunction

  function automatic void buildModel(input bit tb,
                                     input logic [9:0] a,
                                     input bit r);
    int plan[$];
    int bytesQ[$];
    int av, rv, hi, attempts, ack;
    bit fin, nacked;
    plan = ackPlan;
    av = int'(a);
    rv = int'(r);
    hi = 240 + (av / 256) * 2;
    if (!tb) begin
      bytesQ.push_back((av % 128) * 2 + rv);
    end else begin
      bytesQ.push_back(hi);
      bytesQ.push_back(av % 256);
      if (r) begin
        bytesQ.push_back(-1);
        bytesQ.push_back(hi + 1);
      end
    end
    expEv.delete();
    expAck = 0;
    expNack = 0;
    attempts = 0;
    fin = 0;
    while (!fin) begin
      nacked = 0;
      expEv.push_back(-1);
      for (int i = 0; i < bytesQ.size(); i++) begin
        if (bytesQ[i] < 0) begin
          expEv.push_back(-1);
          continue;
        end
        for (int b = 7; b >= 0; b--)
          expEv.push_back((bytesQ[i] >> b) & 1);
        expEv.push_back(2);
        ack = (plan.size() > 0) ? plan.pop_front() : 1;
        if (ack == 0) begin
          if (RETRY_ON && attempts < MAXR) begin
            attempts++;
            nacked = 1;
          end else begin
            expNack = 1;
            fin = 1;
          end
          break;
        end
      end
      if (!nacked && !fin) begin
        expAck = 1;
        fin = 1;
      end
    end
    expRetry = RETRY_ON ? attempts : 0;
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    bit_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runPhase(input string tag, input bit tb,
                          input logic [9:0] a, input bit r,
                          input int reqTicks);
    int ticks, sinceTick, cyc, bad;
    bit gotDone;
    ticks = 0;
    sinceTick = 0;
    cyc = 0;
    gotDone = 0;
    buildModel(tb, a, r);
    obsEv.delete();
    @(negedge clk);
    start = 1'b1;
    ten_bit = tb;
    addr = a;
    rw = r;
    bit_tick = 1'($urandom_range(0, 1));
    slave_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    ten_bit = 1'($urandom);
    addr = 10'($urandom);
    rw = 1'($urandom);
    check({tag, " busy@N+1"}, int'(busy), 1);
    check({tag, " start_req@N+1"}, int'(start_req), 1);
    check({tag, " cleared"},
          int'({addr_ack, nack_err, retry_cnt}), 0);
    while (cyc < 3000) begin
      if (done) begin
        gotDone = 1;
        break;
      end
      bit_tick = 1'b0;
      slave_ack = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        bit_tick = 1'b1;
        ticks++;
        sinceTick = 0;
        if (start_req)
          obsEv.push_back(-1);
        else if (bit_valid)
          obsEv.push_back(int'(sda_bit));
        else if (ack_slot) begin
          obsEv.push_back(2);
          slave_ack = (ackPlan.size() > 0)
                    ? 1'(ackPlan.pop_front()) : 1'b1;
        end else
          obsEv.push_back(9);
      end
      start = (busy && $urandom_range(0, 9) == 0);
      @(negedge clk);
      cyc++;
      sinceTick++;
    end
    start = 1'b0;
    check({tag, " done seen"}, int'(gotDone), 1);
    if (gotDone) begin
      check({tag, " done 1 cyc after tick"}, sinceTick, 1);
      check({tag, " busy low with done"}, int'(busy), 0);
      check({tag, " tick count"}, ticks, expEv.size());
      if (reqTicks > 0)
        check({tag, " ticks to done"}, ticks, reqTicks);
      bad = (obsEv.size() == expEv.size()) ? -1 : -2;
      for (int i = 0; i < obsEv.size() && bad == -1; i++)
        if (i < expEv.size() && obsEv[i] != expEv[i])
          bad = i;
      check({tag, " slot sequence (first bad idx)"}, bad, -1);
      check({tag, " addr_ack"}, int'(addr_ack), expAck);
      check({tag, " nack_err"}, int'(nack_err), expNack);
      check({tag, " stop_req"}, int'(stop_req), expNack);
      check({tag, " retry_cnt"}, int'(retry_cnt), expRetry);
      bit_tick = 1'b1;
      @(negedge clk);
      bit_tick = 1'b0;
      check({tag, " done one cycle"}, int'(done), 0);
      check({tag, " idle after done"},
            int'({busy, start_req, bit_valid, ack_slot}), 0);
      check({tag, " addr_ack held"}, int'(addr_ack), expAck);
      check({tag, " nack_err held"}, int'(nack_err), expNack);
    end else begin
      doReset();
    end
    ackPlan.delete();
  endtask

  initial begin
    int nTick, nDone;
    rst_n = 1'b0;
    start = 1'b0;
    ten_bit = 1'b0;
    addr = '0;
    rw = 1'b0;
    bit_tick = 1'b0;
    slave_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", allOut(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle outputs", allOut(), 0);

    runPhase("7b wr 050", 1'b0, 10'h050, 1'b0, TICKS_7BIT);
    runPhase("10b rd 2A5", 1'b1, 10'h2A5, 1'b1, TICKS_10BIT_RD);
    runPhase("10b wr 3C3", 1'b1, 10'h3C3, 1'b0, TICKS_10BIT_WR);
    runPhase("7b rd 7F", 1'b0, 10'h07F, 1'b1, TICKS_7BIT);

    ackPlan = '{0};
    runPhase("7b nack B0", 1'b0, 10'h050, 1'b0, 0);
    ackPlan = '{0, 0, 0, 0};
    runPhase("nack always", 1'b0, 10'h123, 1'b1, 0);
    ackPlan = '{0, 1};
    runPhase("nack then ack", 1'b0, 10'h02A, 1'b0, 0);
    ackPlan = '{1, 0};
    runPhase("10b nack B1", 1'b1, 10'h155, 1'b1, 0);
    ackPlan = '{1, 1, 0, 1, 1, 1};
    runPhase("10b rd nack B2", 1'b1, 10'h0F0, 1'b1, 0);

    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 8; j++)
        ackPlan.push_back(($urandom_range(0, 3) != 0) ? 1 : 0);
      runPhase($sformatf("rand%0d", k), 1'($urandom),
               10'($urandom), 1'($urandom), 0);
    end

    // abandon a 10-bit phase in the middle of B1
    @(negedge clk);
    start = 1'b1;
    ten_bit = 1'b1;
    addr = 10'h2A5;
    rw = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nTick = 0;
    for (int c = 0; c < 200 && nTick < 13; c++) begin
      bit_tick = 1'b1;
      slave_ack = 1'b1;
      start = bit_valid;
      nTick++;
      @(negedge clk);
    end
    bit_tick = 1'b0;
    start = 1'b0;
    check("mid-B1 shifting", int'(bit_valid), 1);
    check("mid-B1 start ignored", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort outputs zero", allOut(), 0);
    rst_n = 1'b1;
    nDone = 0;
    for (int c = 0; c < 40; c++) begin
      bit_tick = 1'($urandom_range(0, 1));
      slave_ack = 1'b1;
      @(negedge clk);
      if (done || busy)
        nDone++;
    end
    bit_tick = 1'b0;
    check("no done after abort", nDone, 0);
    runPhase("after abort", 1'b0, 10'h050, 1'b0, TICKS_7BIT);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/i2c_addr_sequencer.md
# i2c_addr_sequencer

Address-phase sequencer for the I2C master. It is the parametrised successor of the 7-bit slave-address shifter. It supports 7-bit and 10-bit addressing, transmits MSB-first as the I2C standard requires, issues the 10-bit read repeated START, and reports ACK/NACK per byte. It sits between the transaction controller (start, address, R/W) and the bit-timing engine, which supplies `bit_tick` and performs START, STOP and SDA/SCL pin drive.

## Interface
Parameters:
- `MAX_RETRY`, default 3. Number of extra address attempts after a NACK; only used with `I2C_ADDR_RETRY_EN`.
- `RETRY_W`, default 2. Width of `retry_cnt`; must hold `MAX_RETRY`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin an address phase; sampled only in IDLE.
- `ten_bit` in 1: 1 = 10-bit address mode; captured with `start`.
- `addr` in 10: slave address; 7-bit mode uses `addr[6:0]`; captured with `start`.
- `rw` in 1: 0 = write, 1 = read; captured with `start`.
- `bit_tick` in 1: one-cycle strobe from the timing engine marking the end of each SCL bit slot.
- `slave_ack` in 1: decoded ACK for the current ACK slot (1 = ACK); sampled on `bit_tick` in ACK.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `start_req` out 1: requests a (repeated) START; held until `bit_tick`.
- `sda_bit` out 1: address bit to drive; valid while `bit_valid`.
- `bit_valid` out 1: high during the 8 data-bit slots of each byte.
- `ack_slot` out 1: high during ACK slots; the timing engine releases SDA.
- `done` out 1: one-cycle pulse at the end of the address phase.
- `addr_ack` out 1: 1 = all bytes ACKed; held until the next accepted `start`.
- `nack_err` out 1: 1 = final NACK; held until the next accepted `start`.
- `stop_req` out 1: one-cycle pulse with `done` when `nack_err` is set.
- `retry_cnt` out `RETRY_W`: attempts used in the current phase.

## Operation
- States: IDLE, START, SHIFT, ACK, RSTART, DONE.
- Byte sequence:
  - 7-bit mode: B0 = {`addr[6:0]`, `rw`}.
  - 10-bit write: B0 = {5'b11110, `addr[9:8]`, 0}, then B1 = `addr[7:0]`.
  - 10-bit read: B0 and B1 as for 10-bit write, then RSTART, then B2 = {5'b11110, `addr[9:8]`, 1}.
- IDLE -> START on `start`. Capture `ten_bit`, `addr` and `rw`; clear `addr_ack`, `nack_err` and `retry_cnt`.
- START and RSTART: `start_req` = 1. On `bit_tick`, load the next byte and go to SHIFT.
- SHIFT: `bit_valid` = 1 and `sda_bit` = current MSB. Each `bit_tick` shifts left one bit. The 8th tick goes to ACK.
- ACK: `ack_slot` = 1. On `bit_tick`, sample `slave_ack`:
  - ACK and more bytes remain: go to SHIFT, or to RSTART before B2.
  - ACK on the last byte: go to DONE with `addr_ack` = 1.
  - NACK: go to DONE with `nack_err` = 1 and `stop_req` pulse, unless a retry applies (see Configuration).
- DONE: `done` pulse for one cycle, then IDLE.
- `start` while `busy` is ignored. `bit_tick` in IDLE or DONE is ignored. `start` and `bit_tick` together in IDLE: `start` is accepted and the tick is ignored.
- Reset at any point: the next edge returns to IDLE with all outputs 0. A phase in progress is abandoned; no `done` is produced.

## Timing
- `start` at cycle N: `busy` = 1 and `start_req` = 1 at N+1.
- The first `bit_tick` after N+1 ends START. `sda_bit` then shows B0[7] the cycle after that tick.
- Each bit occupies exactly one `bit_tick` interval. A byte plus its ACK takes 9 ticks; a (repeated) START takes 1 tick.
- Minimum ticks to `done`: 7-bit = 10; 10-bit write = 19; 10-bit read = 29.
- `done` is asserted the cycle after the final ACK tick. `busy` falls in the same cycle as `done`.
- All state changes are registered; no output depends combinationally on an input.

## Configuration
- Macro `I2C_ADDR_RETRY_EN`, defined:
  - A NACK with `retry_cnt` < `MAX_RETRY` increments `retry_cnt` and goes to START, restarting from B0.
  - No `done`, `stop_req` or `nack_err` is produced for that NACK.
  - A NACK with `retry_cnt` = `MAX_RETRY` ends the phase as a final NACK.
- Macro undefined:
  - Every NACK is final.
  - `retry_cnt` is tied to 0 and `MAX_RETRY` is unused.

## Structure
- Package `i2c_addr_pkg`: state enum, constant `TEN_BIT_PREFIX` = 5'b11110, byte-index type (2 bits), and the `bit_tick` count constants used by the bench.
- Sub-module `i2c_byte_shifter`: 8-bit MSB-first load/shift register with a 3-bit counter. It advances on `bit_tick` and flags the last bit. The top level holds the FSM, byte selection and retry logic.

## Test plan
- 7-bit write, `addr` = 10'h050, `rw` = 0, all ACK -> `sda_bit` sequence 1010_0000; `done` with `addr_ack` = 1 after 10 ticks.
- 10-bit read, `addr` = 10'h2A5, all ACK -> bytes F4, A5, then `start_req` re-asserted, then F5; `done` after 29 ticks.
- 7-bit, NACK on B0 with the macro undefined -> `done`, `nack_err` = 1, `stop_req` pulse; `addr_ack` = 0.
- Macro defined, `MAX_RETRY` = 2, NACK always -> 3 START attempts, `retry_cnt` reaches 2, then final `nack_err`; NACK on attempt 1 and ACK on attempt 2 -> `addr_ack` = 1, `retry_cnt` = 1.
- `start` pulsed during SHIFT and `rst_n` = 0 mid-B1 -> `start` ignored; after reset all outputs 0 and IDLE, with no `done` pulse.
